// File: rtl/cpu2core_sysid_regs.sv
// cpu2core_sysid_regs: system-ID / housekeeping slave on the shared Avalon-MM bus.
// Provides ID, build timestamp and configuration words, a 64-bit uptime counter
// with a coherent high-word shadow, per-core ready flags and scratch registers.
// Reads are registered with a fixed latency of one cycle; there is no waitrequest.
module cpu2core_sysid_regs #(
  parameter logic [31:0] SYSID_ID        = 32'h0000_0000,
  parameter logic [31:0] SYSID_TIMESTAMP = 32'd1446555800,
  parameter int          NUM_CORES       = 2,   // 1..32
  parameter int          SCRATCH_WORDS   = 4,   // 1..8
  parameter int          ADDR_W          = 4    // fixed at 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  // Word addresses of the fixed registers
  localparam logic [3:0] ADDR_ID        = 4'd0;
  localparam logic [3:0] ADDR_TIMESTAMP = 4'd1;
  localparam logic [3:0] ADDR_CONFIG    = 4'd2;
  localparam logic [3:0] ADDR_UP_LO     = 4'd3;
  localparam logic [3:0] ADDR_UP_HI     = 4'd4;
  localparam logic [3:0] ADDR_READY_SET = 4'd5;
  localparam logic [3:0] ADDR_READY_CLR = 4'd6;

  // Configuration word: core count, scratch count, block version
  localparam logic [7:0]  CFG_CORES   = 8'(NUM_CORES);
  localparam logic [7:0]  CFG_SCRATCH = 8'(SCRATCH_WORDS);
  localparam logic [15:0] CFG_VERSION = 16'h0002;
  localparam logic [31:0] CONFIG_WORD = {CFG_CORES, CFG_SCRATCH, CFG_VERSION};
  localparam logic [3:0]  SCR_COUNT   = 4'(SCRATCH_WORDS);

  logic [63:0]          uptime;
  logic [31:0]          uptime_hi_shadow;
  logic [NUM_CORES-1:0] ready;
  // Scratch storage is sized to the full 8-word window; entries beyond
  // SCRATCH_WORDS are never written and stay at zero.
  logic [31:0]          scratch [8];

  logic [2:0]  scr_idx;
  logic        scr_hit;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] rd_value;

  // Address decode helpers; a read wins over a simultaneous write
  always_comb begin
    scr_idx = address[2:0];
    scr_hit = address[3] && ({1'b0, address[2:0]} < SCR_COUNT);
    rd_en   = read;
    wr_en   = write && !read;
  end

  // Read data multiplexer, sampled into readdata on an accepted read
  always_comb begin
    rd_value = 32'd0;
    case (address)
      ADDR_ID:        rd_value = SYSID_ID;
      ADDR_TIMESTAMP: rd_value = SYSID_TIMESTAMP;
      ADDR_CONFIG:    rd_value = CONFIG_WORD;
      ADDR_UP_LO:     rd_value = uptime[31:0];
      ADDR_UP_HI:     rd_value = uptime_hi_shadow;
      ADDR_READY_SET: rd_value = 32'(ready);
      ADDR_READY_CLR: rd_value = 32'(ready);
      default: begin
        if (scr_hit) begin
          rd_value = scratch[scr_idx];
        end else begin
          rd_value = 32'd0;
        end
      end
    endcase
  end

  // Free-running uptime counter; a write to UPTIME_LO restarts it from zero
  always_ff @(posedge clock) begin
    if (reset) begin
      uptime <= 64'd0;
    end else if (wr_en && (address == ADDR_UP_LO)) begin
      uptime <= 64'd0;
    end else begin
      uptime <= uptime + 64'd1;
    end
  end

  // High-word shadow captured by the same read that returns the low word
  always_ff @(posedge clock) begin
    if (reset) begin
      uptime_hi_shadow <= 32'd0;
    end else if (rd_en && (address == ADDR_UP_LO)) begin
      uptime_hi_shadow <= uptime[63:32];
    end else begin
      uptime_hi_shadow <= uptime_hi_shadow;
    end
  end

  // Per-core ready flags: write-1-to-set at READY_SET, write-1-to-clear at READY_CLR
  always_ff @(posedge clock) begin
    if (reset) begin
      ready <= '0;
    end else if (wr_en && (address == ADDR_READY_SET)) begin
      ready <= ready | writedata[NUM_CORES-1:0];
    end else if (wr_en && (address == ADDR_READY_CLR)) begin
      ready <= ready & ~writedata[NUM_CORES-1:0];
    end else begin
      ready <= ready;
    end
  end

  // Scratch registers; writes outside the implemented range are dropped
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        scratch[i] <= 32'd0;
      end
    end else if (wr_en && scr_hit) begin
      scratch[scr_idx] <= writedata;
    end else begin
      for (int i = 0; i < 8; i++) begin
        scratch[i] <= scratch[i];
      end
    end
  end

  // Registered read response; readdata holds between accepted reads
  always_ff @(posedge clock) begin
    if (reset) begin
      readdata      <= 32'd0;
      readdatavalid <= 1'b0;
    end else if (rd_en) begin
      readdata      <= rd_value;
      readdatavalid <= 1'b1;
    end else begin
      readdata      <= readdata;
      readdatavalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu2core_sysid_regs.sv
// Self-checking bench for cpu2core_sysid_regs: directed register-map steps
// followed by random bus traffic, compared against a behavioural model.
module tb_cpu2core_sysid_regs;

  logic        clock;
  logic        reset;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;

  int checks;
  int errors;

  // Behavioural model of the register map (default parameters)
  logic [63:0] m_up;
  logic [31:0] m_shadow;
  logic [31:0] m_ready;
  logic [31:0] m_scr [4];
  logic [31:0] m_rdata;
  logic        m_valid;

  cpu2core_sysid_regs dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  // 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] model_read(input logic [3:0] a);
    int n;
    n = int'(a);
    if (n == 0)                 return 32'h0000_0000;
    else if (n == 1)            return 32'd1446555800;
    else if (n == 2)            return 32'h0204_0002;
    else if (n == 3)            return m_up[31:0];
    else if (n == 4)            return m_shadow;
    else if (n == 5 || n == 6)  return m_ready;
    else if (n >= 8 && n < 12)  return m_scr[n - 8];
    else                        return 32'd0;
  endfunction

  // One bus cycle: drive at negedge, update model at posedge, check 1 ns later
  task automatic step(input logic rd, input logic wr, input logic rs,
                      input logic [3:0] a, input logic [31:0] d, input string tag);
    int n;
    logic clr;
    n = int'(a);
    read = rd; write = wr; reset = rs; address = a; writedata = d;
    @(posedge clock);
    if (rs) begin
      m_up = 64'd0; m_shadow = 32'd0; m_ready = 32'd0;
      for (int i = 0; i < 4; i++) m_scr[i] = 32'd0;
      m_rdata = 32'd0; m_valid = 1'b0;
    end else begin
      clr = 1'b0;
      if (rd) begin
        m_rdata = model_read(a);
        m_valid = 1'b1;
        if (n == 3) m_shadow = m_up[63:32];
      end else begin
        m_valid = 1'b0;
      end
      if (wr && !rd) begin
        if (n == 3) clr = 1'b1;
        else if (n == 5) m_ready = m_ready | (d & 32'h3);
        else if (n == 6) m_ready = m_ready & ~(d & 32'h3);
        else if (n >= 8 && n < 12) m_scr[n - 8] = d;
      end
      m_up = clr ? 64'd0 : m_up + 64'd1;
    end
    #1;
    checks++;
    assert (readdatavalid === m_valid) else begin
      errors++;
      $error("FAIL %s readdatavalid got %0b expected %0b", tag, readdatavalid, m_valid);
    end
    checks++;
    assert (readdata === m_rdata) else begin
      errors++;
      $error("FAIL %s readdata got %h expected %h", tag, readdata, m_rdata);
    end
    @(negedge clock);
  endtask

  initial begin
    checks = 0; errors = 0;
    read = 1'b0; write = 1'b0; reset = 1'b1; address = 4'd0; writedata = 32'd0;

    // Reset state
    step(1'b0, 1'b0, 1'b1, 4'd0, 32'd0, "reset0");
    step(1'b1, 1'b0, 1'b1, 4'd0, 32'd0, "reset1");

    // First cycle out of reset: uptime reads 0, then ID words back-to-back
    step(1'b1, 1'b0, 1'b0, 4'd3, 32'd0, "uptime_after_reset");
    step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, "id");
    step(1'b1, 1'b0, 1'b0, 4'd1, 32'd0, "timestamp");
    step(1'b1, 1'b0, 1'b0, 4'd2, 32'd0, "config");

    // Coherent snapshot across a low-word carry
    force dut.uptime = 64'h0000_0000_FFFF_FFFE;
    m_up = 64'h0000_0000_FFFF_FFFE;
    #1 release dut.uptime;
    step(1'b1, 1'b0, 1'b0, 4'd3, 32'd0, "snap_lo");
    step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, "snap_idle1");
    step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, "snap_idle2");
    step(1'b1, 1'b0, 1'b0, 4'd4, 32'd0, "snap_hi");

    // Uptime clear: cleared at the write, one increment before the read samples it
    step(1'b0, 1'b1, 1'b0, 4'd3, 32'h1234_0000, "up_clear_wr");
    step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, "up_clear_idle");
    step(1'b1, 1'b0, 1'b0, 4'd3, 32'd0, "up_clear_rd");

    // Ready flags
    step(1'b0, 1'b1, 1'b0, 4'd5, 32'hFFFF_FFFF, "ready_set_wr");
    step(1'b1, 1'b0, 1'b0, 4'd5, 32'd0, "ready_set_rd");
    step(1'b0, 1'b1, 1'b0, 4'd6, 32'h0000_0001, "ready_clr_wr");
    step(1'b1, 1'b0, 1'b0, 4'd6, 32'd0, "ready_clr_rd");

    // Scratch and unmapped words
    step(1'b0, 1'b1, 1'b0, 4'd8,  32'hDEAD_BEEF, "scr8_wr");
    step(1'b0, 1'b1, 1'b0, 4'd11, 32'h1234_5678, "scr11_wr");
    step(1'b1, 1'b0, 1'b0, 4'd8,  32'd0, "scr8_rd");
    step(1'b1, 1'b0, 1'b0, 4'd11, 32'd0, "scr11_rd");
    step(1'b0, 1'b1, 1'b0, 4'd12, 32'hCAFE_F00D, "scr12_wr");
    step(1'b1, 1'b0, 1'b0, 4'd12, 32'd0, "scr12_rd");
    step(1'b0, 1'b1, 1'b0, 4'd7,  32'hCAFE_F00D, "unmapped7_wr");
    step(1'b1, 1'b0, 1'b0, 4'd7,  32'd0, "unmapped7_rd");

    // Simultaneous read and write: read wins, write dropped
    step(1'b1, 1'b1, 1'b0, 4'd8, 32'hA5A5_A5A5, "rw_collide");
    step(1'b1, 1'b0, 1'b0, 4'd8, 32'd0, "rw_after");

    // Reset mid-sequence with a read in the reset cycle
    step(1'b1, 1'b0, 1'b1, 4'd8, 32'd0, "reset_read");
    step(1'b1, 1'b0, 1'b0, 4'd3, 32'd0, "post_reset_up");
    step(1'b1, 1'b0, 1'b0, 4'd8, 32'd0, "post_reset_scr8");
    step(1'b1, 1'b0, 1'b0, 4'd5, 32'd0, "post_reset_ready");
    step(1'b1, 1'b0, 1'b0, 4'd4, 32'd0, "post_reset_hi");

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 63) == 0), 4'($urandom_range(0, 15)),
           $urandom(), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
